// File: rtl/dpi_int_pkg.sv
// dpi_int_pkg: shared SynFull/ProNoC request, delivery and queue-state types
package dpi_int_pkg;
  localparam int NOC_NE = 4;
  localparam int DST_W = 4;
  localparam int ID_W = 8;
  localparam int SIZE_W = 4;
  typedef struct packed {
    logic valid;
    logic [DST_W-1:0] dest;
    logic [DST_W-1:0] src;
    logic [ID_W-1:0] id;
    logic [SIZE_W-1:0] size;
  } req_t;
  typedef struct packed {
    logic valid;
    logic [DST_W-1:0] src;
    logic [ID_W-1:0] id;
  } deliver_t;
  typedef enum logic [1:0] {SQ_IDLE = 2'd0, SQ_RUN = 2'd1, SQ_DRAIN = 2'd2, SQ_DONE = 2'd3} synq_state_t;
endpackage

// File: rtl/synfull_ep_fifo.sv
// synfull_ep_fifo: single-endpoint request FIFO; head reads as all-zero when empty
module synfull_ep_fifo
  import dpi_int_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  req_t din,
  output req_t head,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  req_t mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign head = empty ? '0 : mem[rd];
  always_ff @(posedge clk) if (push) mem[wr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/synfull_inject_queue.sv
// synfull_inject_queue: per-endpoint injection FIFOs with outstanding/drop counters and run/drain/done FSM
module synfull_inject_queue
  import dpi_int_pkg::*;
#(
  parameter int NE = NOC_NE,
  parameter int DEPTH = 4,
  parameter int OUTST_W = 16,
  parameter int DROP_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 trace_done_i,
  input  req_t     [NE-1:0]    trace_req_all_i,
  output logic     [NE-1:0]    trace_ready_all_o,
  input  logic     [NE-1:0]    ne_ready_all_i,
  output req_t     [NE-1:0]    noc_req_all_o,
  input  deliver_t [NE-1:0]    noc_del_all_i,
  output logic [OUTST_W-1:0]   outstanding_o,
  output logic [DROP_W-1:0]    drop_cnt_o,
  output logic [1:0]           state_o,
  output logic                 err_o,
  output logic                 endCom_o
);
  localparam int CW = $clog2(NE + 1);
  synq_state_t state, state_n;
  logic [NE-1:0] full, empty, push, pop, drop, dvalid;
  logic accept, under, over, del_unused;
  logic [CW-1:0] npop, ndel, ndrop;
  logic [OUTST_W:0] up, diff;
  logic [DROP_W:0] dsum;
  assign accept = state == SQ_RUN || state == SQ_DRAIN;
  assign del_unused = ^noc_del_all_i;
  for (genvar k = 0; k < NE; k++) begin : g_ep
    assign trace_ready_all_o[k] = accept && !full[k];
    assign push[k] = trace_req_all_i[k].valid && trace_ready_all_o[k];
    assign drop[k] = trace_req_all_i[k].valid && !trace_ready_all_o[k];
    assign pop[k] = !empty[k] && ne_ready_all_i[k];
    assign dvalid[k] = noc_del_all_i[k].valid;
    synfull_ep_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk(clk_i), .rst(rst_i), .push(push[k]), .pop(pop[k]),
      .din(trace_req_all_i[k]), .head(noc_req_all_o[k]), .full(full[k]), .empty(empty[k])
    );
  end
  assign npop = CW'($countones(pop));
  assign ndel = CW'($countones(dvalid));
  assign ndrop = CW'($countones(drop));
  // One extra bit catches both underflow (up < ndel) and overflow (carry into the top bit)
  assign up = {1'b0, outstanding_o} + (OUTST_W+1)'(npop);
  assign under = up < (OUTST_W+1)'(ndel);
  assign diff = up - (OUTST_W+1)'(ndel);
  assign over = !under && diff[OUTST_W];
  assign dsum = {1'b0, drop_cnt_o} + (DROP_W+1)'(ndrop);
  always_comb begin
    state_n = state;
    if (state == SQ_IDLE && start_i) state_n = SQ_RUN;
    if (state == SQ_RUN && trace_done_i) state_n = SQ_DRAIN;
    if (state == SQ_DRAIN && &empty && outstanding_o == '0 && !(|pop) && !(|dvalid)) state_n = SQ_DONE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= SQ_IDLE;
      outstanding_o <= '0;
      drop_cnt_o <= '0;
      err_o <= 1'b0;
    end else begin
      state <= state_n;
      outstanding_o <= under ? '0 : over ? '1 : diff[OUTST_W-1:0];
      drop_cnt_o <= dsum[DROP_W] ? '1 : dsum[DROP_W-1:0];
      err_o <= err_o || under || over;
    end
  end
  assign state_o = state;
  assign endCom_o = state == SQ_DONE;
endmodule

// File: tb/tb_synfull_inject_queue.sv
// tb_synfull_inject_queue: directed checks of push/pop, drops, outstanding counting, FSM and reset
module tb_synfull_inject_queue;
  import dpi_int_pkg::*;
  logic clk = 0, rst = 1, start = 0, tdone = 0, err, endcom;
  req_t [3:0] treq, nreq;
  deliver_t [3:0] del;
  logic [3:0] tready, neready;
  logic [15:0] outst;
  logic [31:0] dropc;
  logic [1:0] st;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  synfull_inject_queue #(.NE(4), .DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .trace_done_i(tdone),
    .trace_req_all_i(treq), .trace_ready_all_o(tready), .ne_ready_all_i(neready),
    .noc_req_all_o(nreq), .noc_del_all_i(del), .outstanding_o(outst),
    .drop_cnt_o(dropc), .state_o(st), .err_o(err), .endCom_o(endcom)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask
  task automatic req(input int k, input int dest, input int id);
    treq[k] = '0;
    treq[k].valid = 1'b1;
    treq[k].dest = DST_W'(dest);
    treq[k].src = DST_W'(k);
    treq[k].id = ID_W'(id);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, st, 0);
    chk({tag, "_ready"}, tready, 0);
    chk({tag, "_nvalid"}, {nreq[3].valid, nreq[2].valid, nreq[1].valid, nreq[0].valid}, 0);
    chk({tag, "_outst"}, outst, 0);
    chk({tag, "_drop"}, dropc, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_end"}, endcom, 0);
  endtask
  initial begin
    treq = '0;
    del = '0;
    neready = '0;
    tick();
    tick();
    rst = 0;
    chk_reset("rst");
    start = 1;
    tick();
    start = 0;
    chk("run_state", st, 1);
    chk("run_ready", tready, 4'hf);
    // single request on ep0, popped the cycle after it becomes visible
    neready = 4'b1101;
    req(0, 3, 7);
    tick();
    treq = '0;
    chk("ep0_valid", nreq[0].valid, 1);
    chk("ep0_id", nreq[0].id, 7);
    chk("ep0_dest", nreq[0].dest, 3);
    chk("ep0_out0", outst, 0);
    tick();
    chk("ep0_popped", nreq[0].valid, 0);
    chk("ep0_out1", outst, 1);
    del[3].valid = 1;
    tick();
    del = '0;
    chk("del_out", outst, 0);
    chk("del_err", err, 0);
    // fill ep1 while its injector stalls; fifth push is dropped
    for (int i = 0; i < 5; i++) begin
      req(1, 2, i);
      tick();
      if (i == 3) chk("ep1_full_ready", tready[1], 0);
    end
    treq = '0;
    chk("ep1_drop", dropc, 1);
    neready[1] = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ep1_order%0d", i), nreq[1].id, i);
      tick();
    end
    chk("ep1_empty", nreq[1].valid, 0);
    chk("ep1_out4", outst, 4);
    del[0].valid = 1;
    del[1].valid = 1;
    tick();
    del = '0;
    chk("out2", outst, 2);
    // all four endpoints pop while two deliveries arrive
    neready = '0;
    for (int k = 0; k < 4; k++) req(k, k, 10 + k);
    tick();
    treq = '0;
    chk("four_valid", {nreq[3].valid, nreq[2].valid, nreq[1].valid, nreq[0].valid}, 4'hf);
    chk("four_id3", nreq[3].id, 13);
    neready = 4'hf;
    del[0].valid = 1;
    del[1].valid = 1;
    tick();
    del = '0;
    chk("pop4_out", outst, 4);
    chk("pop4_empty", {nreq[3].valid, nreq[2].valid, nreq[1].valid, nreq[0].valid}, 0);
    del[0].valid = 1;
    tick();
    del = '0;
    chk("out3", outst, 3);
    // drain with two queued and three outstanding
    neready = '0;
    req(2, 0, 20);
    req(3, 0, 21);
    tick();
    treq = '0;
    tdone = 1;
    tick();
    tdone = 0;
    chk("drain_state", st, 2);
    neready = 4'hf;
    tick();
    chk("drain_out5", outst, 5);
    chk("drain_hold1", st, 2);
    del = '0;
    for (int k = 0; k < 4; k++) del[k].valid = 1;
    tick();
    del = '0;
    chk("drain_out1", outst, 1);
    chk("drain_hold2", st, 2);
    del[0].valid = 1;
    tick();
    del = '0;
    chk("drain_out0", outst, 0);
    chk("drain_hold3", st, 2);
    chk("drain_noend", endcom, 0);
    tick();
    chk("done_state", st, 3);
    chk("done_end", endcom, 1);
    chk("done_ready", tready, 0);
    req(0, 1, 30);
    tick();
    treq = '0;
    chk("done_drop", dropc, 2);
    chk("done_noq", nreq[0].valid, 0);
    // delivery with nothing outstanding
    chk("pre_err", err, 0);
    del[0].valid = 1;
    tick();
    del = '0;
    chk("under_err", err, 1);
    chk("under_out", outst, 0);
    tick();
    chk("err_sticky", err, 1);
    chk("done_hold", st, 3);
    // reset, then multi-drop popcount while IDLE
    rst = 1;
    tick();
    rst = 0;
    chk_reset("rst2");
    for (int k = 0; k < 4; k++) req(k, 0, k);
    tick();
    treq = '0;
    chk("idle_drop4", dropc, 4);
    chk("idle_state", st, 0);
    // reset in the middle of DRAIN with a queued request
    start = 1;
    tick();
    start = 0;
    neready = '0;
    req(2, 1, 40);
    tick();
    treq = '0;
    tdone = 1;
    tick();
    tdone = 0;
    chk("mid_drain", st, 2);
    chk("mid_queued", nreq[2].valid, 1);
    rst = 1;
    tick();
    chk_reset("rst3");
    rst = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
